// File: rtl/cordic_vectoring_if.sv
// Request/response bundle for the vectoring CORDIC: operands and a start
// strobe toward the core, busy/done status and the result back.
interface cordic_vectoring_if #(
   parameter int IN_W  = 6,
   parameter int INT_W = 8
);
   logic                    start;
   logic signed [IN_W-1:0]  x_in;
   logic signed [IN_W-1:0]  y_in;
   logic                    busy;
   logic                    done;
   logic signed [INT_W-1:0] angle_out;
   logic        [INT_W-1:0] mag_out;

   modport master (
      output start, x_in, y_in,
      input  busy, done, angle_out, mag_out
   );

   modport slave (
      input  start, x_in, y_in,
      output busy, done, angle_out, mag_out
   );
endinterface

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: drives Y toward zero one micro-rotation per clock,
// accumulating the binary angle (atan2) in Z and the gain-scaled magnitude
// in X. Companion to the rotation-mode sine/cosine core.
module cordic_vectoring #(
   parameter int IN_W  = 6,
   parameter int INT_W = 8,
   parameter int ITER  = 6
) (
   input logic               clk,
   input logic               reset,
   cordic_vectoring_if.slave bus
);
   localparam int I_W = 3;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state_q;
   logic [I_W-1:0]          i_q;
   logic signed [INT_W-1:0] x_q, y_q, z_q;
   logic signed [INT_W-1:0] x_d, y_d, z_d;
   logic signed [INT_W-1:0] x_ext, y_ext;
   logic signed [INT_W-1:0] x_pre, y_pre, z_pre;
   logic                    busy_q, done_q;
   logic signed [INT_W-1:0] angle_q;
   logic        [INT_W-1:0] mag_q;

   // NOTE: the atan table is pure combinational constant logic, so it needs
   // no reset and holds no state of its own.
   function automatic logic signed [INT_W-1:0] atan_rom(input logic [I_W-1:0] idx);
      case (idx)
         3'd0:    return INT_W'(16);
         3'd1:    return INT_W'(9);
         3'd2:    return INT_W'(5);
         3'd3:    return INT_W'(2);
         default: return INT_W'(1);
      endcase
   endfunction

   // Sign-extend operands and fold left-half-plane vectors into the right
   // half plane by a +/-90 degree pre-rotation.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      x_pre = '0;
      y_pre = '0;
      z_pre = '0;
      x_ext = {{(INT_W-IN_W){bus.x_in[IN_W-1]}}, bus.x_in};
      y_ext = {{(INT_W-IN_W){bus.y_in[IN_W-1]}}, bus.y_in};
      if (!x_ext[INT_W-1]) begin
         x_pre = x_ext;
         y_pre = y_ext;
         z_pre = '0;
      end else if (!y_ext[INT_W-1]) begin
         x_pre = y_ext;
         y_pre = -x_ext;
         z_pre = INT_W'(32);
      end else begin
         x_pre = -y_ext;
         y_pre = x_ext;
         z_pre = -INT_W'(32);
      end
   end

   // One micro-rotation: rotate clockwise when Y is non-negative, else
   // counter-clockwise, so Y converges on zero.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      if (!y_q[INT_W-1]) begin
         x_d = x_q + (y_q >>> i_q);
         y_d = y_q - (x_q >>> i_q);
         z_d = z_q + atan_rom(i_q);
      end else begin
         x_d = x_q - (y_q >>> i_q);
         y_d = y_q + (x_q >>> i_q);
         z_d = z_q - atan_rom(i_q);
      end
   end

   // Control FSM with datapath registers and registered result/status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state is written with non-blocking assignments so
         // every register samples pre-edge values.
         state_q <= IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         angle_q <= '0;
         mag_q   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  x_q     <= x_pre;
                  y_q     <= y_pre;
                  z_q     <= z_pre;
                  i_q     <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               i_q <= i_q + 1'b1;
               if (i_q == I_W'(ITER - 1)) begin
                  angle_q <= z_d;
                  mag_q   <= x_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.angle_out = angle_q;
   assign bus.mag_out   = mag_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for the vectoring CORDIC: reset state, axis and quadrant
// cases, start-while-busy, restart from DONE, mid-run reset and a
// round-trip sweep against ideal (cos, sin) vectors.
module tb_cordic_vectoring;
   localparam int IN_W  = 6;
   localparam int INT_W = 8;
   localparam int ITER  = 6;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   cordic_vectoring_if #(.IN_W(IN_W), .INT_W(INT_W)) bus ();

   cordic_vectoring #(.IN_W(IN_W), .INT_W(INT_W), .ITER(ITER)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a one-cycle start; returns #1 after the accepting edge.
   task automatic pulse_start(input int x, input int y);
      @(negedge clk);
      bus.start = 1'b1;
      bus.x_in  = IN_W'(x);
      bus.y_in  = IN_W'(y);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Count edges until done; lat = -1 if the budget expires.
   task automatic wait_done(output int lat, output bit busy_ok);
      lat     = -1;
      busy_ok = bus.busy;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = k;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   task automatic run_vector(input int x, input int y, output int lat,
                             output int ang, output int mag, output bit busy_ok);
      pulse_start(x, y);
      wait_done(lat, busy_ok);
      ang = int'(bus.angle_out);
      mag = int'(bus.mag_out);
   endtask

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
   endfunction

   task automatic test_reset();
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.y_in  = '0;
      #3;
      n_cmp += 4;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
      if (bus.angle_out !== '0) begin n_err++; $display("FAIL reset_angle: got %0d want 0", bus.angle_out); end
      if (bus.mag_out !== '0) begin n_err++; $display("FAIL reset_mag: got %0d want 0", bus.mag_out); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_vector(input string name, input int x, input int y,
                              input int exp_ang, input int exp_mag);
      int lat, ang, mag;
      bit busy_ok;
      run_vector(x, y, lat, ang, mag, busy_ok);
      n_cmp += 4;
      if (lat !== ITER) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, lat, ITER); end
      if (!busy_ok) begin n_err++; $display("FAIL %s_busy: got busy profile wrong want high until done", name); end
      if (ang !== exp_ang) begin n_err++; $display("FAIL %s_angle: got %0d want %0d", name, ang, exp_ang); end
      if (mag !== exp_mag) begin n_err++; $display("FAIL %s_mag: got %0d want %0d", name, mag, exp_mag); end
   endtask

   task automatic test_back_to_back();
      int lat, ang, mag;
      bit busy_ok;
      pulse_start(20, 0);
      @(posedge clk);
      @(posedge clk);
      pulse_start(0, 20);
      n_cmp++;
      if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ignored_start_busy: got %b want 1", bus.busy); end
      wait_done(lat, busy_ok);
      n_cmp += 3;
      if (lat !== ITER - 3) begin n_err++; $display("FAIL ignored_start_latency: got %0d want %0d", lat, ITER - 3); end
      if (bus.angle_out !== 8'sd0) begin n_err++; $display("FAIL ignored_start_angle: got %0d want 0", bus.angle_out); end
      if (bus.mag_out !== 8'd35) begin n_err++; $display("FAIL ignored_start_mag: got %0d want 35", bus.mag_out); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp += 2;
      if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_hold: got %b want 1", bus.done); end
      if (bus.mag_out !== 8'd35) begin n_err++; $display("FAIL result_hold: got %0d want 35", bus.mag_out); end
      pulse_start(0, 20);
      n_cmp += 2;
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL restart_done_drop: got %b want 0", bus.done); end
      if (bus.busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", bus.busy); end
      wait_done(lat, busy_ok);
      ang = int'(bus.angle_out);
      mag = int'(bus.mag_out);
      n_cmp += 3;
      if (lat !== ITER) begin n_err++; $display("FAIL restart_latency: got %0d want %0d", lat, ITER); end
      if (ang !== 32) begin n_err++; $display("FAIL restart_angle: got %0d want 32", ang); end
      if (mag !== 33) begin n_err++; $display("FAIL restart_mag: got %0d want 33", mag); end
   endtask

   task automatic test_reset_mid_calc();
      pulse_start(20, 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      n_cmp += 4;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", bus.done); end
      if (bus.angle_out !== '0) begin n_err++; $display("FAIL midreset_angle: got %0d want 0", bus.angle_out); end
      if (bus.mag_out !== '0) begin n_err++; $display("FAIL midreset_mag: got %0d want 0", bus.mag_out); end
      #9;
      reset = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL midreset_no_result: got done=%b want 0", bus.done); end
      test_vector("after_reset", 20, 0, 0, 35);
   endtask

   task automatic test_round_trip();
      int lat, ang, mag, c, s, diff;
      bit busy_ok;
      real r;
      for (int a = -31; a <= 31; a++) begin
         r = real'(a) * 3.14159265358979 / 64.0;
         c = rnd(31.0 * $cos(r));
         s = rnd(31.0 * $sin(r));
         run_vector(c, s, lat, ang, mag, busy_ok);
         diff = (ang > a) ? ang - a : a - ang;
         n_cmp += 2;
         if (diff > 3) begin n_err++; $display("FAIL roundtrip_angle a=%0d: got %0d want within 3", a, ang); end
         if (lat !== ITER) begin n_err++; $display("FAIL roundtrip_latency a=%0d: got %0d want %0d", a, lat, ITER); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_vector("pos_x", 20, 0, 0, 35);
      test_vector("pos_y", 0, 20, 32, 33);
      test_vector("neg_x", -20, 0, 64, 33);
      test_vector("third_quad", -20, -20, -48, 49);
      test_vector("min_x", -32, 0, 64, 53);
      test_back_to_back();
      test_reset_mid_calc();
      test_round_trip();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
